// File: rtl/arrow_scheduler.sv
// Attack-phase arrow pattern sequencer: paces spawn requests on frame ticks,
// tracks live arrows and reports busy/finished to the phase controller.
module arrow_scheduler #(
  parameter int unsigned NUM_ARROWS   = 24,
  parameter int unsigned FIRST_DELAY  = 30,
  parameter int unsigned BASE_GAP     = 60,
  parameter logic [3:0]  ATTACK_STATE = 4'b1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic [3:0]            state_in,
  input  logic [3:0]            turn_in,
  input  logic                  spawn_ready_in,
  input  logic [NUM_ARROWS-1:0] arrow_done_in,
  output logic                  spawn_valid_out,
  output logic [4:0]            spawn_slot_out,
  output logic [1:0]            spawn_dir_out,
  output logic [2:0]            spawn_speed_out,
  output logic                  spawn_inversed_out,
  output logic                  busy_out,
  output logic                  finished_out
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic [3:0]            prev_state;
  logic [1:0]            turn;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      frame_cnt;
  logic [CNT_W-1:0]      gap;
  logic [NUM_ARROWS-1:0] live_mask;

  logic                  frame_tick_c;
  logic                  in_attack_c;
  logic                  start_c;
  logic [CNT_W-1:0]      frame_cnt_inc_c;
  logic [IDX_W-1:0]      idx_inc_c;
  logic [IDX_W-1:0]      arrow_count_c;
  logic [NUM_ARROWS-1:0] spawn_bit_c;
  logic                  unused_turn_c;

  assign frame_tick_c    = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign in_attack_c     = (state_in == ATTACK_STATE);
  assign start_c         = in_attack_c && (prev_state != state_in);
  // Saturating so a long gap can never wrap the counter back to a false match.
  assign frame_cnt_inc_c = (frame_cnt == '1) ? frame_cnt : frame_cnt + CNT_W'(1);
  assign idx_inc_c       = idx + IDX_W'(1);
  assign arrow_count_c   = IDX_W'(8) + IDX_W'({turn, 2'b00});
  assign spawn_bit_c     = NUM_ARROWS'(1) << idx;
  assign unused_turn_c   = ^turn_in[3:2];

  // Phase sequencer; start and abort override every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      prev_state         <= 4'b1010;
      turn               <= '0;
      idx                <= '0;
      frame_cnt          <= '0;
      gap                <= '0;
      live_mask          <= '0;
      spawn_valid_out    <= 1'b0;
      spawn_slot_out     <= '0;
      spawn_dir_out      <= '0;
      spawn_speed_out    <= '0;
      spawn_inversed_out <= 1'b0;
      busy_out           <= 1'b0;
      finished_out       <= 1'b0;
    end else begin
      prev_state   <= state_in;
      finished_out <= 1'b0;
      live_mask    <= live_mask & ~arrow_done_in;
      if (start_c) begin
        state           <= S_WAIT;
        turn            <= turn_in[1:0];
        idx             <= '0;
        frame_cnt       <= '0;
        gap             <= CNT_W'(FIRST_DELAY);
        live_mask       <= '0;
        spawn_valid_out <= 1'b0;
        busy_out        <= 1'b1;
      end else if ((state != S_IDLE) && !in_attack_c) begin
        state           <= S_IDLE;
        live_mask       <= '0;
        spawn_valid_out <= 1'b0;
        busy_out        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: busy_out <= 1'b0;
          S_WAIT: begin
            if (frame_tick_c) begin
              if (frame_cnt_inc_c == gap) begin
                state              <= S_ISSUE;
                frame_cnt          <= '0;
                spawn_valid_out    <= 1'b1;
                spawn_slot_out     <= idx;
                spawn_dir_out      <= idx[1:0] + turn;
                spawn_speed_out    <= 3'(turn) + 3'd1;
                spawn_inversed_out <= (turn == 2'd3) & idx[0];
              end else begin
                frame_cnt <= frame_cnt_inc_c;
              end
            end
          end
          S_ISSUE: begin
            if (spawn_ready_in) begin
              // A same-cycle done for the new slot loses to the set.
              live_mask       <= (live_mask & ~arrow_done_in) | spawn_bit_c;
              spawn_valid_out <= 1'b0;
              idx             <= idx_inc_c;
              gap             <= CNT_W'(BASE_GAP >> turn);
              state           <= (idx_inc_c < arrow_count_c) ? S_WAIT : S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (live_mask == '0) state <= S_DONE;
          end
          S_DONE: begin
            finished_out <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
